// File: rtl/trace_pkg.sv
// Shared definitions for the instruction-trace UART: ASCII constants,
// hex digit conversion and the line FSM state encoding.
package trace_pkg;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] COLON = 8'h3A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } line_state_t;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F' (0x37 = 'A' - 10)
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. Each bit is held for DIV clocks using a down-counting
// baud timer; done pulses during the final clock of the stop bit so the
// caller can queue the next byte on the following edge.
module uart_tx_byte #(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       txd,
  output logic       done
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("uart_tx_byte: clock divider must be at least 2");
    end
  endgenerate

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;

  // bit_cnt 0 is the start bit, 1..8 data, 9 the stop bit
  assign done = active && (baud_cnt == '0) && (bit_cnt == 4'd9);

  // Frame sequencer: start bit on accept, then shift LSB first, then stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else if (!active) begin
      if (start) begin
        active   <= 1'b1;
        baud_cnt <= BAUD_LAST;
        bit_cnt  <= '0;
        shreg    <= data;
        txd      <= 1'b0;
      end
    end else if (baud_cnt != '0) begin
      baud_cnt <= baud_cnt - CW'(1);
    end else if (bit_cnt == 4'd9) begin
      active <= 1'b0;
      txd    <= 1'b1;
    end else begin
      baud_cnt <= BAUD_LAST;
      bit_cnt  <= bit_cnt + 4'd1;
      txd      <= (bit_cnt == 4'd8) ? 1'b1 : shreg[0];
      shreg    <= {1'b0, shreg[7:1]};
    end
  end

endmodule

// File: rtl/inst_trace_uart.sv
// Serial instruction trace: each accepted disassembly string is sent as one
// text line (optional PC prefix, string, CR LF) over an 8N1 UART.
// Optional feature macro: TRACE_PC_EN adds the pc port and an "XXXXXXXX: "
// hex prefix to every line.
//
// state | meaning
// IDLE  | ready for a new line
// LOAD  | hand current character to the serializer
// SEND  | wait for the character frame to finish
// DONE  | one-cycle line completion
module inst_trace_uart
  import trace_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BAUD    = 115200,
  parameter int STR_LEN = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STR_LEN*8-1:0] inst_str,
`ifdef TRACE_PC_EN
  input  logic [31:0]          pc,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int DIV = CLK_HZ / BAUD;
`ifdef TRACE_PC_EN
  localparam int PFX_LEN = 10;
`else
  localparam int PFX_LEN = 0;
`endif
  localparam int LINE_LEN = PFX_LEN + STR_LEN + 2;
  localparam int IW = $clog2(LINE_LEN + 1);

  line_state_t          state, state_nx;
  logic [IW-1:0]        idx;
  logic [STR_LEN*8-1:0] str_buf;
`ifdef TRACE_PC_EN
  logic [31:0]          pc_buf;
`endif
  logic [7:0]           char_sel;
  logic [7:0]           str_byte;
  int                   pos;
  logic                 ser_start;
  logic                 ser_done;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // State register, line buffer capture and character index
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      str_buf <= '0;
`ifdef TRACE_PC_EN
      pc_buf  <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        idx     <= '0;
        str_buf <= inst_str;
`ifdef TRACE_PC_EN
        pc_buf  <= pc;
`endif
      end else if (state == SEND && ser_done) begin
        idx <= idx + IW'(1);
      end
    end
  end

  // Line sequencing: one LOAD/SEND pair per character, then DONE
  always_comb begin
    state_nx  = state;
    ser_start = 1'b0;
    case (state)
      IDLE: if (in_valid) state_nx = LOAD;
      LOAD: begin
        ser_start = 1'b1;
        state_nx  = SEND;
      end
      SEND: if (ser_done) state_nx = (idx == IW'(LINE_LEN - 1)) ? DONE : LOAD;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Character at the current index: prefix, string (NUL shown as space), CR, LF
  always_comb begin
    char_sel = LF;
    str_byte = '0;
    pos      = int'(idx) - PFX_LEN;
`ifdef TRACE_PC_EN
    if (idx < IW'(8)) begin
      char_sel = hex_char(pc_buf[(7 - int'(idx))*4 +: 4]);
    end else if (idx == IW'(8)) begin
      char_sel = COLON;
    end else if (idx == IW'(9)) begin
      char_sel = SPACE;
    end else
`endif
    if (pos >= 0 && pos < STR_LEN) begin
      str_byte = 8'(str_buf >> ((STR_LEN - 1 - pos) * 8));
      char_sel = (str_byte == 8'h00) ? SPACE : str_byte;
    end else if (pos == STR_LEN) begin
      char_sel = CR;
    end
  end

  uart_tx_byte #(.DIV(DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (char_sel),
    .start (ser_start),
    .txd   (txd),
    .done  (ser_done)
  );

endmodule

// File: tb/tb_inst_trace_uart.sv
`timescale 1ns/1ps
module tb_inst_trace_uart;

  localparam int STR_LEN = 19;
`ifdef TRACE_PC_EN
  localparam int LINE_LEN = STR_LEN + 12;
`else
  localparam int LINE_LEN = STR_LEN + 2;
`endif
  // DIV = 10: 10*10+1 = 101 cycles per character, +2 for SEND->DONE->IDLE
  // (2123 for a 21-character line, 3133 with the PC prefix)
  localparam int LAT = LINE_LEN * 101 + 2;

  localparam logic [STR_LEN*8-1:0] S_ADD = " add x01,x02,x03   ";
  localparam logic [STR_LEN*8-1:0] S_LW  = "lw x07,0x10(x02)   ";
  localparam logic [STR_LEN*8-1:0] S_NUL = {8'h00, "sw", 16'h0000, "x5", 96'h0};

  logic                 clk;
  logic                 rst;
  logic [STR_LEN*8-1:0] inst_str;
`ifdef TRACE_PC_EN
  logic [31:0]          pc;
`endif
  logic                 in_valid;
  logic                 in_ready;
  logic                 txd;
  logic                 busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc, acc2;

  logic [7:0] exp_q[$];

  bit         mon_act;
  bit         mon_glitch;
  int         mon_s;
  logic [9:0] mon_bits;
  logic [7:0] mon_exp;

  inst_trace_uart #(
    .CLK_HZ (1_000_000),
    .BAUD   (100_000),
    .STR_LEN(STR_LEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .inst_str(inst_str),
`ifdef TRACE_PC_EN
    .pc      (pc),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .txd     (txd),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_line(input logic [STR_LEN*8-1:0] s);
    logic [7:0] b;
`ifdef TRACE_PC_EN
    logic [79:0] pfx;
    pfx = "00001A3C: ";
    for (int k = 0; k < 10; k++) exp_q.push_back(pfx[(9-k)*8 +: 8]);
`endif
    for (int k = 0; k < STR_LEN; k++) begin
      b = s[(STR_LEN-1-k)*8 +: 8];
      exp_q.push_back((b == 8'h00) ? 8'h20 : b);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // issue one handshake; returns #1 after the accepting edge
  task automatic start_line(input logic [STR_LEN*8-1:0] s);
    inst_str = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc      = cyc;
    in_valid = 1'b0;
    push_line(s);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < LAT + 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: in_ready still low after %0d cycles, required high", name, n);
    end
  endtask

  // UART monitor: decodes frames from txd and scores them against exp_q
  initial begin
    mon_act = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (txd === 1'b0) begin
          mon_act    = 1'b1;
          mon_s      = 0;
          mon_bits   = '0;
          mon_glitch = 1'b0;
        end
      end else begin
        mon_s++;
        if (mon_s % 10 == 0) mon_bits[mon_s/10] = txd;
        else if (txd !== mon_bits[mon_s/10]) mon_glitch = 1'b1;
        if (mon_s == 99) begin
          mon_act = 1'b0;
          check("frame_timing_stop", {30'b0, mon_glitch, mon_bits[9]}, 32'h1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got %02h required none", mon_bits[8:1]);
          end else begin
            mon_exp = exp_q.pop_front();
            check("frame_byte", {24'b0, mon_bits[8:1]}, {24'b0, mon_exp});
          end
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    inst_str = '0;
`ifdef TRACE_PC_EN
    pc       = 32'h0000_1A3C;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic line, latency, and input change after acceptance
    start_line(S_ADD);
    inst_str = S_LW;
    check("acc_busy", busy, 1);
    check("acc_in_ready", in_ready, 0);
    check("load_gap_txd", txd, 1);
    @(posedge clk); #1;
    check("first_start_bit", txd, 0);
    wait_ready("line_add");
    check("line_latency", cyc - acc + 1, LAT);
    check("line_add_drained", exp_q.size(), 0);

    // NUL bytes sent as spaces
    start_line(S_NUL);
    wait_ready("line_nul");
    check("line_nul_drained", exp_q.size(), 0);

    // reset during character 5, frame bit 3 (data bit 2 = 0)
    start_line(S_ADD);
    repeat (541) @(posedge clk);
    #1;
    check("pre_rst_txd", txd, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_txd", txd, 1);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    exp_q.delete();
    start_line(S_LW);
    wait_ready("line_after_rst");
    check("after_rst_drained", exp_q.size(), 0);

    // back-to-back with in_valid held high, then a pulse while busy
    inst_str = S_LW;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    push_line(S_LW);
    inst_str = S_ADD;
    wait_ready("b2b_first");
    @(posedge clk); #1;
    acc2 = cyc;
    push_line(S_ADD);
    check("b2b_accept_in_ready", in_ready, 0);
    check("b2b_gap", acc2 - acc, LAT);
    in_valid = 1'b0;
    inst_str = S_NUL;
    repeat (300) @(posedge clk);
    #1;
    check("busy_mid_line", busy, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pulse_in_ready", in_ready, 0);
    wait_ready("b2b_second");
    check("b2b_second_latency", cyc - acc2, LAT - 1);
    repeat (LAT) @(posedge clk);
    #1;
    check("no_extra_line_busy", busy, 0);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_monitor_idle", {31'b0, mon_act}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
